// File: rtl/controle_io.sv
// controle_io: IN/OUT handshake between the CPU, board switches, push-button and display
module controle_io #(
    parameter int DEB_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_req,
    input  logic        io_out_req,
    input  logic [15:0] Switches,
    input  logic        enter,
    input  logic [31:0] Data_output,
    output logic        halt_cpu,
    output logic [31:0] ES,
    output logic        in_valid,
    output logic [31:0] Saida,
    output logic        out_valid
);
    typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

    localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

    state_t      state_q, state_d;
    logic        sync1_q, sync_enter_q;
    logic        deb_q, deb_d;
    logic [15:0] cnt_q, cnt_d;
    logic        press_q, release_q;
    logic [31:0] es_q, es_d, saida_q, saida_d;
    logic        out_valid_d, out_valid_q;

    // debounce: count consecutive disagreeing cycles, flip the level on the last one
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_enter_q != deb_q) begin
            if (cnt_q == CNT_LAST) deb_d = ~deb_q;
            else cnt_d = cnt_q + 16'd1;
        end
    end

    // synchronizer, debounce state and one-cycle press/release pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync_enter_q <= 1'b0;
            deb_q        <= 1'b0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
        end else begin
            sync1_q      <= enter;
            sync_enter_q <= sync1_q;
            deb_q        <= deb_d;
            cnt_q        <= cnt_d;
            press_q      <= deb_d & ~deb_q;
            release_q    <= ~deb_d & deb_q;
        end
    end

    // IN sequencing, stall request and OUT capture (OUT is blocked while stalling)
    always_comb begin
        state_d  = state_q;
        es_d     = es_q;
        halt_cpu = 1'b0;
        in_valid = 1'b0;
        case (state_q)
            IDLE: begin
                halt_cpu = io_in_req;
                if (io_in_req) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                halt_cpu = 1'b1;
                if (press_q) begin
                    state_d = WAIT_RELEASE;
                    es_d    = {16'b0, Switches};
                end
            end
            WAIT_RELEASE: begin
                halt_cpu = 1'b1;
                if (release_q) state_d = DONE;
            end
            DONE: begin
                in_valid = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = io_out_req & ~halt_cpu;
        saida_d     = out_valid_d ? Data_output : saida_q;
    end

    // FSM state and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            es_q        <= '0;
            saida_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            es_q        <= es_d;
            saida_q     <= saida_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ES        = es_q;
    assign Saida     = saida_q;
    assign out_valid = out_valid_q;
endmodule

// File: doc/controle_io.md
CONTROLE_IO -- requirements
Module: controle_io

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, number of consecutive synchronized cycles the enter level must differ from its debounced level before it is accepted; legal range 2..65535.
REQ-002 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port io_in_req, input, 1, IN instruction decoded by the control unit; held until halt_cpu deasserts.
REQ-005 SHALL have port io_out_req, input, 1, OUT instruction decoded by the control unit.
REQ-006 SHALL have port Switches, input, 16, board switches.
REQ-007 SHALL have port enter, input, 1, raw asynchronous push-button, active-high.
REQ-008 SHALL have port Data_output, input, 32, processor data for OUT.
REQ-009 SHALL have port halt_cpu, output, 1, stall request to the processor.
REQ-010 SHALL have port ES, output, 32, captured input word for register write-back.
REQ-011 SHALL have port in_valid, output, 1, one-cycle pulse indicating ES is fresh.
REQ-012 SHALL have port Saida, output, 32, display register.
REQ-013 SHALL have port out_valid, output, 1, one-cycle pulse after Saida update.

Function
REQ-014 SHALL pass enter through a 2-flop synchronizer; the second flop output is sync_enter.
REQ-015 SHALL keep a debounced level deb and a counter: counter clears whenever sync_enter equals deb; counter increments while they differ; deb toggles and counter clears on the edge where counter equals DEB_CYCLES-1 and they still differ.
REQ-016 SHALL register a press pulse, high for exactly one cycle after deb goes 0->1, and a release pulse, high for exactly one cycle after deb goes 1->0.
REQ-017 SHALL ignore enter glitches shorter than DEB_CYCLES synchronized cycles; deb SHALL NOT change for them.
REQ-018 SHALL implement FSM states IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
REQ-019 IDLE -> WAIT_PRESS when io_in_req=1; otherwise stay.
REQ-020 WAIT_PRESS -> WAIT_RELEASE on press; on that edge ES <= {16'b0, Switches}.
REQ-021 WAIT_RELEASE -> DONE on release; ES holds.
REQ-022 DONE -> IDLE unconditionally; in_valid=1 only in DONE.
REQ-023 halt_cpu SHALL be combinational: 1 when (state=IDLE and io_in_req=1) or state is WAIT_PRESS or WAIT_RELEASE; 0 otherwise, including DONE.
REQ-024 A press pulse in IDLE, DONE or WAIT_RELEASE SHALL be discarded; a press arriving in WAIT_PRESS SHALL require a full release before the next IN completes.
REQ-025 io_in_req still high in IDLE directly after DONE SHALL start a new IN sequence needing a new press.
REQ-026 On an edge with io_out_req=1 and halt_cpu=0, Saida <= Data_output and out_valid SHALL be 1 in the following cycle only; otherwise Saida holds.
REQ-027 io_in_req and io_out_req high together in IDLE: halt_cpu=1 blocks the OUT; the IN sequence starts; OUT SHALL complete on the first edge after DONE where io_out_req is still high.
REQ-028 ES and Saida SHALL change only on the edges stated in REQ-020 and REQ-026.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, synchronizer flops 0, deb 0, counter 0, press/release pulses 0, ES 0, Saida 0, in_valid 0, out_valid 0.
REQ-030 Reset asserted in WAIT_PRESS or WAIT_RELEASE SHALL abort the IN: halt_cpu falls to 0 unless io_in_req=1; ES stays 0.
REQ-031 After reset release, a held-high enter SHALL be debounced as a new press.

Verification
REQ-032 DEB_CYCLES=4, io_in_req=1, Switches=16'hA5C3, enter rises before edge k -> deb high after edge k+5, ES=32'h0000A5C3 after edge k+6; release then gives in_valid for one cycle; halt_cpu low in DONE.
REQ-033 enter pulses 3 synchronized cycles wide in WAIT_PRESS -> deb stays 0; ES unchanged; halt_cpu stays 1.
REQ-034 io_out_req=1, Data_output=32'hDEADBEEF in IDLE -> Saida=32'hDEADBEEF after that edge; out_valid high one cycle.
REQ-035 io_in_req and io_out_req together, Data_output=32'h12345678 -> Saida unchanged until after DONE; then Saida=32'h12345678.
REQ-036 reset pulsed low in WAIT_RELEASE with io_in_req=0 -> halt_cpu=0 and ES=0 immediately; state IDLE.
REQ-037 Back-to-back IN with enter held across DONE -> second sequence stays in WAIT_PRESS until enter is released and pressed again.
